// File: rtl/decoder_2to4_reg.sv
// Registered 2-to-4 line decoder with active-high enable and optional output inversion.
// Optional sticky per-line hit flags are built when DECODER_2TO4_HIT_TRACK_EN is defined.
module decoder_2to4_reg #(
  parameter int ACTIVE_LOW = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] A,
  input  logic       E,
`ifdef DECODER_2TO4_HIT_TRACK_EN
  input  logic       hit_clr,
  output logic [3:0] hit,
`endif
  output logic [3:0] D,
  output logic       D_valid
);

  // Inactive level of every D line; the asserted line is its complement.
  localparam logic [3:0] IDLE_LEVEL = (ACTIVE_LOW != 0) ? 4'b1111 : 4'b0000;

  logic [3:0] dec_logic;
  logic [3:0] dec_phys;

  always_comb begin
    dec_logic = 4'b0000;
    if (E) begin
      dec_logic[A] = 1'b1;
    end
    dec_phys = dec_logic ^ IDLE_LEVEL;
  end

  // D_valid is a plain valid flag with no back-pressure: it is high for
  // exactly the cycles in which D carries an asserted line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      D       <= IDLE_LEVEL;
      D_valid <= 1'b0;
    end else begin
      D       <= dec_phys;
      D_valid <= E;
    end
  end

`ifdef DECODER_2TO4_HIT_TRACK_EN
  // Clear and set in one edge: a line decoded alongside hit_clr survives.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hit <= 4'b0000;
    end else begin
      hit <= (hit_clr ? 4'b0000 : hit) | dec_logic;
    end
  end
`endif

endmodule

// File: tb/tb_decoder_2to4_reg.sv
// Bench for decoder_2to4_reg: active-high and active-low instances side by side,
// directed steps followed by randomized steps against an arithmetic reference model.
module tb_decoder_2to4_reg;

  logic       clk;
  logic       rst;
  logic [1:0] A;
  logic       E;
  logic [3:0] D;
  logic       D_valid;
  logic [3:0] D_al;
  logic       D_valid_al;
`ifdef DECODER_2TO4_HIT_TRACK_EN
  logic       hit_clr;
  logic [3:0] hit;
  logic [3:0] hit_al;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state: expected logical line number or none, and lines seen since clear.
  int exp_line;
  bit hit_seen [4];

  decoder_2to4_reg #(.ACTIVE_LOW(0)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .A       (A),
    .E       (E),
`ifdef DECODER_2TO4_HIT_TRACK_EN
    .hit_clr (hit_clr),
    .hit     (hit),
`endif
    .D       (D),
    .D_valid (D_valid)
  );

  decoder_2to4_reg #(.ACTIVE_LOW(1)) u_dut_al (
    .clk     (clk),
    .rst     (rst),
    .A       (A),
    .E       (E),
`ifdef DECODER_2TO4_HIT_TRACK_EN
    .hit_clr (hit_clr),
    .hit     (hit_al),
`endif
    .D       (D_al),
    .D_valid (D_valid_al)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [3:0] model_d(input int line, input bit active_low);
    int v;
    v = (line < 0) ? 0 : (1 << line);
    if (active_low) v = 15 - v;
    return 4'(v);
  endfunction

  function automatic logic [3:0] model_hit();
    int v;
    v = 0;
    for (int i = 0; i < 4; i++) if (hit_seen[i]) v += (1 << i);
    return 4'(v);
  endfunction

  task automatic check4(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check4({tag, ".D"}, D, model_d(exp_line, 1'b0));
    check4({tag, ".D_valid"}, {3'b000, D_valid}, {3'b000, exp_line >= 0});
    check4({tag, ".D_al"}, D_al, model_d(exp_line, 1'b1));
    check4({tag, ".D_valid_al"}, {3'b000, D_valid_al}, {3'b000, exp_line >= 0});
`ifdef DECODER_2TO4_HIT_TRACK_EN
    check4({tag, ".hit"}, hit, model_hit());
    check4({tag, ".hit_al"}, hit_al, model_hit());
`endif
  endtask

  // Driver: apply inputs away from the edge, update the model at the edge, sample #1 later.
  task automatic step(input string tag, input logic [1:0] a, input logic e, input logic clr);
    @(negedge clk);
    A = a;
    E = e;
`ifdef DECODER_2TO4_HIT_TRACK_EN
    hit_clr = clr;
`endif
    @(posedge clk);
    if (clr) for (int i = 0; i < 4; i++) hit_seen[i] = 1'b0;
    exp_line = e ? int'(a) : -1;
    if (e) hit_seen[a] = 1'b1;
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset between edges; checked immediately, then held across an edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2;
    rst = 1'b1;
    exp_line = -1;
    for (int i = 0; i < 4; i++) hit_seen[i] = 1'b0;
    #1;
    check_all({tag, ".immediate"});
    A = 2'b11;
    E = 1'b1;
    @(posedge clk);
    #1;
    check_all({tag, ".held"});
    @(negedge clk);
    rst = 1'b0;
    E = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    A = 2'b00;
    E = 1'b0;
`ifdef DECODER_2TO4_HIT_TRACK_EN
    hit_clr = 1'b0;
`endif
    exp_line = -1;
    for (int i = 0; i < 4; i++) hit_seen[i] = 1'b0;

    // Reset before any clock edge, then first decode.
    #2;
    rst = 1'b1;
    #1;
    check_all("reset_no_edge");
    @(negedge clk);
    rst = 1'b0;
    step("first_decode", 2'b00, 1'b1, 1'b0);

    // Disabled: A is don't-care.
    step("disabled_a01", 2'b01, 1'b0, 1'b0);
    step("disabled_a10", 2'b10, 1'b0, 1'b0);

    // Full sweep, back-to-back.
    for (int i = 0; i < 4; i++) step($sformatf("sweep_a%0d", i), 2'(i), 1'b1, 1'b0);

    // Enable toggle.
    step("toggle_on", 2'b10, 1'b1, 1'b0);
    step("toggle_off", 2'b10, 1'b0, 1'b0);
    step("toggle_on2", 2'b11, 1'b1, 1'b0);

    // Hit tracking: clear with a simultaneous decode keeps that line.
    async_reset("reset_pre_hit");
    step("hit_a00", 2'b00, 1'b1, 1'b0);
    step("hit_a11", 2'b11, 1'b1, 1'b0);
    step("hit_clr_a01", 2'b01, 1'b1, 1'b1);
    step("hit_clr_idle", 2'b10, 1'b0, 1'b1);

    // Mid-operation reset discards the registered decode.
    step("pre_midreset", 2'b01, 1'b1, 1'b0);
    async_reset("reset_mid");

    // Randomized stimulus.
    for (int n = 0; n < 60; n++) begin
      step($sformatf("rand_%0d", n), 2'($urandom_range(3)), 1'($urandom_range(3) != 0),
           1'($urandom_range(7) == 0));
      if ($urandom_range(19) == 0) async_reset($sformatf("rand_reset_%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
